pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_hazard_det.sv | 22 ++
 rtl/pipe_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/redirect sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic {
    PEND_FENCE = 1'b0,
    PEND_ECALL = 1'b1
  } pend_t;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use comparator: a load in EX whose rd is consumed by the instruction in ID.
module pipe_hazard_det (
  input  logic       ex_fire,
  input  logic       ex_mem_ren,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
  assign w_rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
  // x0 is never a real dependency
  assign load_use  = ex_fire & ex_mem_ren & (ex_rd != 5'd0) & id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and redirect sequencer: load-use stalls, branch/mret redirects,
// fence/ecall LSU drain, ecall trap entry and ebreak halt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_MAX = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_fire,
  input  logic [31:0]      ex_pc,
  input  logic             ex_branch_taken,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_branch_target,
  input  logic             ex_is_fence,
  input  logic             ex_ecall,
  input  logic             ex_mret,
  input  logic             ex_ebreak,
  input  logic             ex_mem_ren,
  input  logic [4:0]       ex_rd,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             mem_busy,
  input  logic [31:0]      csr_mtvec,
  input  logic [31:0]      csr_mepc,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             icache_inv,
  output logic             trap_wen,
  output logic [31:0]      trap_mepc,
  output logic [31:0]      trap_mcause,
  output logic             halt,
  output logic             drain_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int             DCW   = $clog2(DRAIN_MAX + 1);
  localparam logic [DCW-1:0] DMAX  = DCW'(DRAIN_MAX);
  localparam logic [DCW-1:0] DLAST = DCW'(DRAIN_MAX - 1);

  state_t           r_state;
  pend_t            r_pend_kind;
  logic [31:0]      r_saved_pc;
  logic [DCW-1:0]   r_drain_cnt;
  logic             r_halt;
  logic             r_drain_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  state_t      w_state_next;
  pend_t       w_pend_sel;
  logic        w_save;
  logic        w_load_use;
  logic        w_stall_if;
  logic        w_stall_id;
  logic        w_flush_id;
  logic        w_flush_ex;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_icache_inv;
  logic        w_trap_wen;
  logic [31:0] w_trap_mepc;
  logic [31:0] w_trap_mcause;

  pipe_hazard_det u_hazard (
    .ex_fire    (ex_fire),
    .ex_mem_ren (ex_mem_ren),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .load_use   (w_load_use)
  );

  always_comb begin
    w_stall_if       = 1'b0;
    w_stall_id       = 1'b0;
    w_flush_id       = 1'b0;
    w_flush_ex       = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_icache_inv     = 1'b0;
    w_trap_wen       = 1'b0;
    w_trap_mepc      = '0;
    w_trap_mcause    = '0;
    w_state_next     = r_state;
    w_save           = 1'b0;
    w_pend_sel       = r_pend_kind;
    case (r_state)
      ST_RUN: begin
        // Chain order is the event priority; load-use only when nothing else fires
        if (ex_fire && ex_ebreak) begin
          {w_stall_if, w_flush_id, w_flush_ex} = 3'b111;
          w_state_next = ST_HALT;
        end else if (ex_fire && ex_ecall) begin
          {w_stall_if, w_flush_id, w_flush_ex} = 3'b111;
          w_save       = 1'b1;
          w_pend_sel   = PEND_ECALL;
          w_state_next = ST_DRAIN;
        end else if (ex_fire && ex_mret) begin
          {w_redirect_valid, w_flush_id, w_flush_ex} = 3'b111;
          w_redirect_pc = csr_mepc;
        end else if (ex_fire && ex_is_fence) begin
          {w_stall_if, w_flush_id, w_flush_ex} = 3'b111;
          w_save       = 1'b1;
          w_pend_sel   = PEND_FENCE;
          w_state_next = ST_DRAIN;
        end else if (ex_fire && (ex_is_jump || ex_branch_taken)) begin
          {w_redirect_valid, w_flush_id, w_flush_ex} = 3'b111;
          w_redirect_pc = ex_branch_target;
        end else if (w_load_use) begin
          {w_stall_if, w_stall_id, w_flush_ex} = 3'b111;
        end
      end
      ST_DRAIN: begin
        {w_stall_if, w_flush_id, w_flush_ex} = 3'b111;
        if (!mem_busy) begin
          if (r_pend_kind == PEND_FENCE) begin
            w_redirect_valid = 1'b1;
            w_redirect_pc    = r_saved_pc + 32'd4;
            w_icache_inv     = 1'b1;
            w_state_next     = ST_RUN;
          end else begin
            w_state_next = ST_TRAP;
          end
        end
      end
      ST_TRAP: begin
        {w_redirect_valid, w_flush_id, w_flush_ex, w_trap_wen} = 4'b1111;
        w_redirect_pc = csr_mtvec;
        w_trap_mepc   = r_saved_pc;
        w_trap_mcause = MCAUSE_ECALL_M;
        w_state_next  = ST_RUN;
      end
      ST_HALT: begin
        {w_stall_if, w_stall_id, w_flush_ex} = 3'b111;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_RUN;
      r_pend_kind     <= PEND_FENCE;
      r_saved_pc      <= '0;
      r_drain_cnt     <= '0;
      r_halt          <= 1'b0;
      r_drain_timeout <= 1'b0;
      r_stall_cycles  <= '0;
      r_flush_count   <= '0;
    end else begin
      r_state        <= w_state_next;
      r_stall_cycles <= r_stall_cycles + CNT_W'(w_stall_if);
      r_flush_count  <= r_flush_count + CNT_W'(w_redirect_valid);
      if (w_save) begin
        r_saved_pc  <= ex_pc;
        r_pend_kind <= w_pend_sel;
        r_drain_cnt <= '0;
      end
      // Counter parks at DRAIN_MAX; the timeout flag stays set until reset
      if (r_state == ST_DRAIN) begin
        if (r_drain_cnt != DMAX) r_drain_cnt <= r_drain_cnt + 1'b1;
        if (r_drain_cnt == DLAST) r_drain_timeout <= 1'b1;
      end
      if (w_state_next == ST_HALT) r_halt <= 1'b1;
    end
  end

  // Combinational controls are forced quiet while reset is held
  assign stall_if       = rst & w_stall_if;
  assign stall_id       = rst & w_stall_id;
  assign flush_id       = rst & w_flush_id;
  assign flush_ex       = rst & w_flush_ex;
  assign redirect_valid = rst & w_redirect_valid;
  assign redirect_pc    = rst ? w_redirect_pc : '0;
  assign icache_inv     = rst & w_icache_inv;
  assign trap_wen       = rst & w_trap_wen;
  assign trap_mepc      = rst ? w_trap_mepc : '0;
  assign trap_mcause    = rst ? w_trap_mcause : '0;
  assign halt           = r_halt;
  assign drain_timeout  = r_drain_timeout;
  assign stall_cycles   = r_stall_cycles;
  assign flush_count    = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DRAIN_MAX=4): load-use, redirects, fence/ecall drain, halt, timeout.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_fire, ex_branch_taken, ex_is_jump, ex_is_fence, ex_ecall, ex_mret, ex_ebreak;
  logic        ex_mem_ren, id_valid, id_use_rs1, id_use_rs2, mem_busy;
  logic [31:0] ex_pc, ex_branch_target, csr_mtvec, csr_mepc;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        stall_if, stall_id, flush_id, flush_ex, redirect_valid, icache_inv, trap_wen;
  logic        halt, drain_timeout;
  logic [31:0] redirect_pc, trap_mepc, trap_mcause, stall_cycles, flush_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32), .DRAIN_MAX(4)) u_dut (
    .clk(clk), .rst(rst), .ex_fire(ex_fire), .ex_pc(ex_pc),
    .ex_branch_taken(ex_branch_taken), .ex_is_jump(ex_is_jump),
    .ex_branch_target(ex_branch_target), .ex_is_fence(ex_is_fence),
    .ex_ecall(ex_ecall), .ex_mret(ex_mret), .ex_ebreak(ex_ebreak),
    .ex_mem_ren(ex_mem_ren), .ex_rd(ex_rd), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .mem_busy(mem_busy), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .icache_inv(icache_inv), .trap_wen(trap_wen),
    .trap_mepc(trap_mepc), .trap_mcause(trap_mcause), .halt(halt),
    .drain_timeout(drain_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ex_fire = 0; ex_pc = '0; ex_branch_taken = 0; ex_is_jump = 0; ex_branch_target = '0;
    ex_is_fence = 0; ex_ecall = 0; ex_mret = 0; ex_ebreak = 0; ex_mem_ren = 0; ex_rd = '0;
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  task automatic do_reset;
    idle();
    mem_busy = 0; csr_mtvec = 32'h8000_0200; csr_mepc = 32'h8000_0300;
    rst = 0;
    tick(); tick();
    rst = 1;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    n_total++; if ({stall_if, stall_id, flush_id, flush_ex, redirect_valid, icache_inv, trap_wen, halt, drain_timeout} !== 9'd0)
      $display("FAIL reset_flags: got %b want 0", {stall_if, stall_id, flush_id, flush_ex, redirect_valid, icache_inv, trap_wen, halt, drain_timeout}); else n_pass++;
    n_total++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count); else n_pass++;
    $display("reset: flags and counters sampled");
  endtask

  task automatic test_load_use;
    do_reset();
    ex_fire = 1; ex_mem_ren = 1; ex_rd = 5'd5; id_valid = 1;
    id_rs1 = 5'd3; id_use_rs1 = 1; id_rs2 = 5'd5; id_use_rs2 = 1;
    #1;
    n_total++; if ({stall_if, stall_id, flush_ex, flush_id, redirect_valid} !== 5'b11100)
      $display("FAIL load_use_stall: got %b want 11100", {stall_if, stall_id, flush_ex, flush_id, redirect_valid}); else n_pass++;
    tick(); idle(); #1;
    n_total++; if ({stall_if, stall_id, flush_ex} !== 3'b000)
      $display("FAIL load_use_one_cycle: got %b want 000", {stall_if, stall_id, flush_ex}); else n_pass++;
    n_total++; if (stall_cycles !== 32'd1)
      $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cycles); else n_pass++;
    ex_fire = 1; ex_mem_ren = 1; ex_rd = 5'd0; id_valid = 1; id_rs2 = 5'd0; id_use_rs2 = 1;
    #1;
    n_total++; if ({stall_if, stall_id, flush_ex} !== 3'b000)
      $display("FAIL load_use_rd0: got %b want 000", {stall_if, stall_id, flush_ex}); else n_pass++;
    tick(); idle();
    $display("load_use: rd=5 stalls one cycle, rd=0 ignored");
  endtask

  task automatic test_branch_over_load_use;
    do_reset();
    ex_fire = 1; ex_branch_taken = 1; ex_branch_target = 32'h8000_0100;
    ex_mem_ren = 1; ex_rd = 5'd5; id_valid = 1; id_rs2 = 5'd5; id_use_rs2 = 1;
    #1;
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0100)
      $display("FAIL branch_redirect: got %b/%h want 1/80000100", redirect_valid, redirect_pc); else n_pass++;
    n_total++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0011)
      $display("FAIL branch_flush_nostall: got %b want 0011", {stall_if, stall_id, flush_id, flush_ex}); else n_pass++;
    tick(); idle(); #1;
    n_total++; if (flush_count !== 32'd1 || redirect_pc !== 32'd0)
      $display("FAIL branch_after: got cnt %0d pc %h want 1/0", flush_count, redirect_pc); else n_pass++;
    ex_fire = 1; ex_mret = 1; ex_is_fence = 1;
    #1;
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0300 || stall_if !== 1'b0)
      $display("FAIL mret_over_fence: got %b/%h/%b want 1/80000300/0", redirect_valid, redirect_pc, stall_if); else n_pass++;
    tick(); idle();
    $display("branch: taken branch beats load-use, mret beats fence");
  endtask

  task automatic test_fence;
    do_reset();
    ex_fire = 1; ex_is_fence = 1; ex_pc = 32'h8000_0040; mem_busy = 1;
    #1;
    n_total++; if ({stall_if, flush_id, flush_ex, redirect_valid} !== 4'b1110)
      $display("FAIL fence_issue: got %b want 1110", {stall_if, flush_id, flush_ex, redirect_valid}); else n_pass++;
    tick(); idle();
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_total++; if ({stall_if, flush_id, flush_ex, redirect_valid, icache_inv} !== 5'b11100)
        $display("FAIL fence_drain%0d: got %b want 11100", c, {stall_if, flush_id, flush_ex, redirect_valid, icache_inv}); else n_pass++;
      tick();
    end
    mem_busy = 0;
    #1;
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0044 || icache_inv !== 1'b1 || stall_if !== 1'b1)
      $display("FAIL fence_exit: got %b/%h/%b/%b want 1/80000044/1/1", redirect_valid, redirect_pc, icache_inv, stall_if); else n_pass++;
    tick(); #1;
    n_total++; if ({icache_inv, redirect_valid, stall_if} !== 3'b000)
      $display("FAIL fence_back_run: got %b want 000", {icache_inv, redirect_valid, stall_if}); else n_pass++;
    n_total++; if (stall_cycles !== 32'd5 || flush_count !== 32'd1)
      $display("FAIL fence_counters: got %0d/%0d want 5/1", stall_cycles, flush_count); else n_pass++;
    $display("fence: 4 drain cycles then redirect 80000044 with icache_inv");
  endtask

  task automatic test_ecall;
    do_reset();
    ex_fire = 1; ex_ecall = 1; ex_is_fence = 1; ex_pc = 32'h8000_0010;
    #1;
    n_total++; if ({stall_if, flush_id, flush_ex, redirect_valid} !== 4'b1110)
      $display("FAIL ecall_issue: got %b want 1110", {stall_if, flush_id, flush_ex, redirect_valid}); else n_pass++;
    tick(); idle(); #1;
    n_total++; if ({stall_if, redirect_valid, trap_wen, icache_inv} !== 4'b1000)
      $display("FAIL ecall_drain: got %b want 1000", {stall_if, redirect_valid, trap_wen, icache_inv}); else n_pass++;
    tick(); #1;
    n_total++; if (trap_wen !== 1'b1 || trap_mepc !== 32'h8000_0010 || trap_mcause !== 32'd11)
      $display("FAIL ecall_trap_csr: got %b/%h/%0d want 1/80000010/11", trap_wen, trap_mepc, trap_mcause); else n_pass++;
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0200 || {stall_if, flush_id, flush_ex} !== 3'b011)
      $display("FAIL ecall_trap_redirect: got %b/%h/%b want 1/80000200/011", redirect_valid, redirect_pc, {stall_if, flush_id, flush_ex}); else n_pass++;
    tick(); #1;
    n_total++; if (trap_wen !== 1'b0 || trap_mepc !== 32'd0 || trap_mcause !== 32'd0 || redirect_valid !== 1'b0)
      $display("FAIL ecall_after: got %b/%h/%h/%b want 0/0/0/0", trap_wen, trap_mepc, trap_mcause, redirect_valid); else n_pass++;
    n_total++; if (flush_count !== 32'd1 || stall_cycles !== 32'd2)
      $display("FAIL ecall_counters: got %0d/%0d want 1/2", flush_count, stall_cycles); else n_pass++;
    $display("ecall: one drain cycle then trap to 80000200, mcause 11");
  endtask

  task automatic test_ebreak;
    do_reset();
    ex_fire = 1; ex_ebreak = 1; ex_is_jump = 1; ex_branch_target = 32'h0000_1234;
    #1;
    n_total++; if (redirect_valid !== 1'b0 || {stall_if, flush_id, flush_ex} !== 3'b111 || halt !== 1'b0)
      $display("FAIL ebreak_issue: got %b/%b/%b want 0/111/0", redirect_valid, {stall_if, flush_id, flush_ex}, halt); else n_pass++;
    tick();
    ex_ebreak = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++; if (halt !== 1'b1 || {stall_if, stall_id, flush_ex, redirect_valid} !== 4'b1110)
        $display("FAIL halt_hold%0d: got %b/%b want 1/1110", c, halt, {stall_if, stall_id, flush_ex, redirect_valid}); else n_pass++;
      tick();
    end
    #2;
    rst = 0;
    #1;
    n_total++; if ({halt, stall_if, stall_id, flush_ex, redirect_valid} !== 5'd0 || stall_cycles !== 32'd0)
      $display("FAIL halt_async_reset: got %b/%0d want 0/0", {halt, stall_if, stall_id, flush_ex, redirect_valid}, stall_cycles); else n_pass++;
    rst = 1;
    #1;
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1234 || stall_if !== 1'b0)
      $display("FAIL halt_reset_to_run: got %b/%h/%b want 1/00001234/0", redirect_valid, redirect_pc, stall_if); else n_pass++;
    tick(); idle();
    $display("ebreak: halt sticky, async reset returns to RUN");
  endtask

  task automatic test_timeout;
    do_reset();
    ex_fire = 1; ex_is_fence = 1; ex_pc = 32'hFFFF_FFFC; mem_busy = 1;
    tick(); idle();
    for (int c = 1; c <= 7; c++) begin
      #1;
      n_total++; if (stall_if !== 1'b1 || redirect_valid !== 1'b0)
        $display("FAIL timeout_wait%0d: got %b/%b want 1/0", c, stall_if, redirect_valid); else n_pass++;
      if (c == 4) begin
        n_total++; if (drain_timeout !== 1'b0)
          $display("FAIL timeout_early: got %b want 0", drain_timeout); else n_pass++;
      end
      if (c == 5) begin
        n_total++; if (drain_timeout !== 1'b1)
          $display("FAIL timeout_set: got %b want 1", drain_timeout); else n_pass++;
      end
      tick();
    end
    mem_busy = 0;
    #1;
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0000 || icache_inv !== 1'b1)
      $display("FAIL timeout_exit_wrap: got %b/%h/%b want 1/00000000/1", redirect_valid, redirect_pc, icache_inv); else n_pass++;
    tick(); #1;
    n_total++; if (drain_timeout !== 1'b1 || stall_cycles !== 32'd9 || flush_count !== 32'd1)
      $display("FAIL timeout_sticky_counts: got %b/%0d/%0d want 1/9/1", drain_timeout, stall_cycles, flush_count); else n_pass++;
    $display("timeout: flag after 4 drain cycles, sticky, pc wraps to 0");
  endtask

  initial begin
    idle();
    mem_busy = 0; csr_mtvec = '0; csr_mepc = '0;
    test_reset();
    test_load_use();
    test_branch_over_load_use();
    test_fence();
    test_ecall();
    test_ebreak();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
